// File: rtl/yousei_pkg.sv
// Shared constants, loader state encoding and page addressing helper for the
// hard-disk to main-memory page loader.
package yousei_pkg;

  localparam int DEF_PAGE_WORDS = 64;
  localparam int DEF_NUM_PAGES  = 16;
  localparam int DEF_DATA_W     = 32;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t LD_IDLE   = 2'd0;
  localparam loader_state_t LD_STREAM = 2'd1;
  localparam loader_state_t LD_DRAIN  = 2'd2;
  localparam loader_state_t LD_FINISH = 2'd3;

  // Physical word address: page number in the high bits, offset in the low
  // `shift` bits (page size is a power of two).
  function automatic logic [31:0] page_addr(input logic [31:0] page,
                                            input logic [31:0] offset,
                                            input int          shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return (page << shift) | (offset & mask);
  endfunction

endpackage

// File: rtl/hd_page_loader.sv
// Streams a contiguous range of HD words into one physical page of main
// memory, one word per cycle, then pulses Done.
module hd_page_loader
  import yousei_pkg::*;
#(
  parameter int PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int NUM_PAGES  = DEF_NUM_PAGES,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic [31:0]                   HdBase,
  input  logic [$clog2(PAGE_WORDS):0]   WordCount,
  input  logic [31:0]                   Page,
  output logic                          HdRead,
  output logic [31:0]                   HdAddr,
  input  logic [DATA_W-1:0]             HdData,
  output logic                          MemWrite,
  output logic [31:0]                   MemAddr,
  output logic [DATA_W-1:0]             MemData,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Error,
  output logic [31:0]                   LoadedPage
);

  localparam int OFF_W = $clog2(PAGE_WORDS);
  localparam int CNT_W = OFF_W + 1;

  loader_state_t     state;
  logic [31:0]       base_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       page_q;
  logic [31:0]       loaded_q;
  logic [CNT_W-1:0]  rd_off;
  logic              wr_valid;
  logic [OFF_W-1:0]  wr_off;
  logic              err_q;
  logic              bad_req;
  logic              last_issue;

  assign bad_req = (WordCount == '0)
                || (WordCount > CNT_W'(PAGE_WORDS))
                || (Page >= 32'(NUM_PAGES));

  assign last_issue = (rd_off == count_q - CNT_W'(1));

  // Write side trails the read side by exactly one cycle, matching HD latency.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= LD_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      page_q   <= '0;
      loaded_q <= '0;
      rd_off   <= '0;
      wr_valid <= 1'b0;
      wr_off   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q    <= 1'b0;
      wr_valid <= (state == LD_STREAM);
      wr_off   <= rd_off[OFF_W-1:0];
      case (state)
        LD_IDLE: begin
          if (Start) begin
            base_q  <= HdBase;
            count_q <= WordCount;
            page_q  <= Page;
            rd_off  <= '0;
            if (bad_req) begin
              err_q <= 1'b1;
            end else begin
              loaded_q <= Page;
              state    <= LD_STREAM;
            end
          end
        end
        LD_STREAM: begin
          rd_off <= rd_off + CNT_W'(1);
          if (last_issue) state <= LD_DRAIN;
        end
        LD_DRAIN:  state <= LD_FINISH;
        LD_FINISH: state <= LD_IDLE;
      endcase
    end
  end

  // Address outputs are forced to zero whenever their strobe is low.
  always_comb begin
    HdRead     = (state == LD_STREAM);
    HdAddr     = HdRead ? (base_q + 32'(rd_off)) : 32'd0;
    MemWrite   = wr_valid;
    MemAddr    = wr_valid ? page_addr(page_q, 32'(wr_off), OFF_W) : 32'd0;
    MemData    = HdData;
    Busy       = (state == LD_STREAM) || (state == LD_DRAIN);
    Done       = (state == LD_FINISH) || err_q;
    Error      = err_q;
    LoadedPage = loaded_q;
  end

endmodule
